// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and defaults for the video burst reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  localparam int DEF_ADDR_W    = 25;
  localparam int DEF_BURST_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/video_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_burst_reader_if
//  Description : Burst request/data bus between the reader and the SDRAM
//                controller. master = reader side, slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_burst_reader_if #(
  parameter int ADDR_W = video_pkg::DEF_ADDR_W
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_valid;
  logic [15:0]       mem_data;
  logic              mem_stop;
  logic              mem_done;

  modport master (
    output mem_req, mem_addr, mem_stop,
    input  mem_ack, mem_valid, mem_data, mem_done
  );

  modport slave (
    input  mem_req, mem_addr, mem_stop,
    output mem_ack, mem_valid, mem_data, mem_done
  );

endinterface
`default_nettype wire

// File: rtl/burst_req_slot.sv
`default_nettype none
// ============================================================================
//  Module      : burst_req_slot
//  Description : One-deep pending request holder. A new load while full
//                replaces the address (latest wins) and pulses dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_req_slot
  import video_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              clear,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              dropped
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dropped_q, dropped_d;

  // Clear wins over load: a load coinciding with clear is the request being
  // served directly, so the slot ends up empty either way.
  always_comb begin
    valid_d   = clear ? 1'b0 : (valid_q | load);
    addr_d    = load ? load_addr : addr_q;
    dropped_d = load & valid_q;
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      dropped_q <= dropped_d;
    end
  end

  assign pend_valid = valid_q;
  assign pend_addr  = addr_q;
  assign dropped    = dropped_q;

endmodule
`default_nettype wire

// File: rtl/video_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : video_burst_reader
//  Description : Turns one-cycle burst requests from the video stage into
//                SDRAM controller bursts and forwards the returned words with
//                one cycle of latency. Supports early termination and one
//                queued request.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_burst_reader
  import video_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 clk_sys_131_072,
  input  logic                 reset_n,
  input  logic                 sd_rd,
  input  logic [ADDR_W-1:0]    sd_rd_addr,
  input  logic                 sd_end_burst,
  output logic                 sd_data_available,
  output logic [15:0]          sd_out,
  output logic                 req_dropped,
  video_burst_reader_if.master mem
);

  localparam int              CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_stop_q, mem_stop_d;
  logic              sd_data_available_q, sd_data_available_d;
  logic [15:0]       sd_out_q, sd_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              burst_over;
  logic              slot_load, slot_clear;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;

  // Requests arriving while busy are parked in the slot
  assign slot_load = sd_rd && (state_q != ST_IDLE);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  burst_req_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk        (clk_sys_131_072),
    .rst_n      (reset_n),
    .load       (slot_load),
    .load_addr  (sd_rd_addr),
    .clear      (slot_clear),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .dropped    (req_dropped)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d             = state_q;
    mem_req_d           = mem_req_q;
    mem_addr_d          = mem_addr_q;
    mem_stop_d          = 1'b0;
    sd_data_available_d = 1'b0;
    sd_out_d            = sd_out_q;
    cnt_d               = cnt_q;
    burst_over          = 1'b0;
    slot_clear          = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (mem.mem_valid) begin
          sd_out_d            = mem.mem_data;
          sd_data_available_d = 1'b1;
          cnt_d               = cnt_inc;
        end
        // A controller-side end beats everything; the last word suppresses
        // an early-end request so no stop is sent for a finished burst.
        if (mem.mem_done) begin
          burst_over = 1'b1;
        end else if (mem.mem_valid && (cnt_inc == LAST_CNT)) begin
          state_d = ST_DRAIN;
        end else if (sd_end_burst) begin
          mem_stop_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem.mem_done) begin
          burst_over = 1'b1;
        end
      end
      default: ;
    endcase

    if (burst_over) begin
      state_d = ST_IDLE;
    end

    // Launch a request from idle or straight off the end of a burst; a fresh
    // sd_rd is newer than anything in the slot, so it takes priority.
    if (((state_q == ST_IDLE) || burst_over) && (sd_rd || pend_valid)) begin
      mem_addr_d = sd_rd ? sd_rd_addr : pend_addr;
      mem_req_d  = 1'b1;
      slot_clear = 1'b1;
      state_d    = ST_REQ;
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= ST_IDLE;
      mem_req_q           <= 1'b0;
      mem_addr_q          <= '0;
      mem_stop_q          <= 1'b0;
      sd_data_available_q <= 1'b0;
      sd_out_q            <= '0;
      cnt_q               <= '0;
    end else begin
      state_q             <= state_d;
      mem_req_q           <= mem_req_d;
      mem_addr_q          <= mem_addr_d;
      mem_stop_q          <= mem_stop_d;
      sd_data_available_q <= sd_data_available_d;
      sd_out_q            <= sd_out_d;
      cnt_q               <= cnt_d;
    end
  end

  assign mem.mem_req        = mem_req_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_stop       = mem_stop_q;
  assign sd_data_available  = sd_data_available_q;
  assign sd_out             = sd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_video_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_burst_reader
//  Description : Self-checking bench for video_burst_reader: directed bursts
//                plus a randomized controller/consumer against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_burst_reader;

  localparam int BL = 8;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sd_rd;
  logic [AW-1:0] sd_rd_addr;
  logic          sd_end_burst;
  logic          sd_data_available;
  logic [15:0]   sd_out;
  logic          req_dropped;

  video_burst_reader_if #(.ADDR_W(AW)) mem_if ();

  video_burst_reader #(.BURST_LEN(BL), .ADDR_W(AW)) u_dut (
    .clk_sys_131_072   (clk),
    .reset_n           (reset_n),
    .sd_rd             (sd_rd),
    .sd_rd_addr        (sd_rd_addr),
    .sd_end_burst      (sd_end_burst),
    .sd_data_available (sd_data_available),
    .sd_out            (sd_out),
    .req_dropped       (req_dropped),
    .mem               (mem_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit            m_req;
  logic [AW-1:0] m_addr;
  bit            m_stream;
  bit            m_wait;
  int            m_left;
  logic [AW-1:0] pend_q[$];
  bit            e_avail, e_stop, e_drop;
  logic [15:0]   e_out;

  // observation log for literal checks
  logic [15:0]   got_words[$];
  int            n_stop, n_drop;

  // random controller emulator state
  int ctl, ack_dly, sent, end_dly;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_addr = '0; m_stream = 0; m_wait = 0; m_left = 0;
    pend_q.delete();
    e_avail = 0; e_stop = 0; e_drop = 0; e_out = '0;
  endtask

  task automatic model_start(input logic [AW-1:0] a);
    m_req  = 1;
    m_addr = a;
  endtask

  // Advance the model by one clock given the inputs currently driven
  task automatic model_step();
    bit finished;
    finished = 0;
    e_avail = 0; e_stop = 0; e_drop = 0;
    if (!m_req && !m_stream && !m_wait) begin
      if (sd_rd) model_start(sd_rd_addr);
      else if (pend_q.size() > 0) model_start(pend_q.pop_front());
    end else begin
      if (sd_rd) begin
        if (pend_q.size() > 0) begin
          e_drop = 1;
          pend_q.delete();
        end
        pend_q.push_back(sd_rd_addr);
      end
      if (m_req) begin
        if (mem_if.mem_ack) begin
          m_req = 0; m_stream = 1; m_left = BL;
        end
      end else if (m_stream) begin
        if (mem_if.mem_valid) begin
          e_avail = 1; e_out = mem_if.mem_data; m_left--;
        end
        if (mem_if.mem_done) begin
          m_stream = 0; finished = 1;
        end else if (m_left == 0) begin
          m_stream = 0; m_wait = 1;
        end else if (sd_end_burst) begin
          e_stop = 1; m_stream = 0; m_wait = 1;
        end
      end else if (mem_if.mem_done) begin
        m_wait = 0; finished = 1;
      end
      if (finished && pend_q.size() > 0) model_start(pend_q.pop_front());
    end
  endtask

  task automatic compare();
    check("mem_req",  {31'd0, mem_if.mem_req},     {31'd0, m_req});
    check("mem_addr", {7'd0, mem_if.mem_addr},     {7'd0, m_addr});
    check("mem_stop", {31'd0, mem_if.mem_stop},    {31'd0, e_stop});
    check("sd_avail", {31'd0, sd_data_available},  {31'd0, e_avail});
    check("sd_out",   {16'd0, sd_out},             {16'd0, e_out});
    check("req_drop", {31'd0, req_dropped},        {31'd0, e_drop});
    if (sd_data_available === 1'b1) got_words.push_back(sd_out);
    if (mem_if.mem_stop === 1'b1) n_stop++;
    if (req_dropped === 1'b1) n_drop++;
  endtask

  task automatic clear_inputs();
    sd_rd = 0; sd_end_burst = 0;
    mem_if.mem_ack = 0; mem_if.mem_valid = 0; mem_if.mem_done = 0;
  endtask

  // Inputs are set at a negedge; the model consumes them, the clock edge
  // happens, and outputs are compared at the following negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    clear_inputs();
  endtask

  task automatic word(input logic [15:0] d);
    mem_if.mem_valid = 1; mem_if.mem_data = d;
  endtask

  task automatic start_log();
    got_words.delete(); n_stop = 0; n_drop = 0;
  endtask

  // Randomized SDRAM controller reacting to the expected bus state
  task automatic emu_drive();
    case (ctl)
      0: if (m_req) begin ack_dly = int'($urandom % 4); ctl = 1; end
      1: begin
        if (ack_dly == 0) begin
          mem_if.mem_ack = 1; ctl = 2; sent = 0;
        end else ack_dly--;
      end
      2: begin
        if (e_stop) begin
          ctl = 3; end_dly = int'($urandom % 3);
        end else if ($urandom % 40 == 0) begin
          mem_if.mem_done = 1; ctl = 0;
        end else if ($urandom % 10 < 7) begin
          word(16'($urandom)); sent++;
          if (sent == BL) begin ctl = 3; end_dly = int'($urandom % 3); end
        end
      end
      default: begin
        mem_if.mem_valid = ($urandom % 2 == 0);
        mem_if.mem_data  = 16'($urandom);
        if (end_dly == 0) begin mem_if.mem_done = 1; ctl = 0; end
        else end_dly--;
      end
    endcase
  endtask

  initial begin
    reset_n = 0;
    sd_rd_addr = '0;
    mem_if.mem_data = '0;
    clear_inputs();
    model_reset();
    ctl = 0;
    start_log();
    @(negedge clk);
    @(negedge clk);
    compare();
    reset_n = 1;
    tick();

    // Full burst at 0x100, ack on third request cycle, words A000..A007
    start_log();
    sd_rd = 1; sd_rd_addr = 25'h100; tick();
    check("t1_req", {31'd0, mem_if.mem_req}, 32'd1);
    check("t1_addr", {7'd0, mem_if.mem_addr}, 32'h100);
    tick();
    tick();
    mem_if.mem_ack = 1; tick();
    for (int i = 0; i < BL; i++) begin
      word(16'(32'hA000 + i)); tick();
      check("t1_avail", {31'd0, sd_data_available}, 32'd1);
      check("t1_word", {16'd0, sd_out}, 32'hA000 + i);
    end
    mem_if.mem_done = 1; tick();
    check("t1_count", got_words.size(), 32'd8);
    check("t1_nstop", n_stop, 32'd0);
    check("t1_idle", {31'd0, mem_if.mem_req}, 32'd0);

    // Early end on word 3: four words out, one stop, rest discarded
    start_log();
    sd_rd = 1; sd_rd_addr = 25'h140; tick();
    mem_if.mem_ack = 1; tick();
    for (int i = 0; i < 4; i++) begin
      word(16'(32'hB000 + i));
      if (i == 3) sd_end_burst = 1;
      tick();
    end
    check("t2_stop", {31'd0, mem_if.mem_stop}, 32'd1);
    for (int i = 4; i < BL; i++) begin word(16'(32'hB000 + i)); tick(); end
    mem_if.mem_done = 1; tick();
    check("t2_count", got_words.size(), 32'd4);
    check("t2_last", {16'd0, got_words[got_words.size()-1]}, 32'hB003);
    check("t2_nstop", n_stop, 32'd1);
    check("t2_idle", {31'd0, mem_if.mem_req}, 32'd0);

    // Two requests during STREAM: one drop, latest address served next
    start_log();
    sd_rd = 1; sd_rd_addr = 25'h180; tick();
    mem_if.mem_ack = 1; tick();
    word(16'hC000); sd_rd = 1; sd_rd_addr = 25'h200; tick();
    word(16'hC001); tick();
    word(16'hC002); sd_rd = 1; sd_rd_addr = 25'h300; tick();
    check("t3_drop", {31'd0, req_dropped}, 32'd1);
    for (int i = 3; i < BL; i++) begin word(16'(32'hC000 + i)); tick(); end
    mem_if.mem_done = 1; tick();
    check("t3_req", {31'd0, mem_if.mem_req}, 32'd1);
    check("t3_addr", {7'd0, mem_if.mem_addr}, 32'h300);
    check("t3_ndrop", n_drop, 32'd1);

    // End request coinciding with the last word: all 8 words, no stop
    start_log();
    mem_if.mem_ack = 1; tick();
    for (int i = 0; i < BL; i++) begin
      word(16'(32'hD000 + i));
      if (i == BL - 1) sd_end_burst = 1;
      tick();
    end
    check("t4_nostop", {31'd0, mem_if.mem_stop}, 32'd0);
    // Request on the mem_done cycle is served with no idle gap
    sd_rd = 1; sd_rd_addr = 25'h3C0; mem_if.mem_done = 1; tick();
    check("t4_req", {31'd0, mem_if.mem_req}, 32'd1);
    check("t4_addr", {7'd0, mem_if.mem_addr}, 32'h3C0);
    check("t4_count", got_words.size(), 32'd8);
    check("t4_nstop", n_stop, 32'd0);

    // Asynchronous reset mid-STREAM
    start_log();
    mem_if.mem_ack = 1; tick();
    word(16'hE000); tick();
    word(16'hE001); tick();
    reset_n = 0;
    #1;
    check("rst_req",   {31'd0, mem_if.mem_req},    32'd0);
    check("rst_addr",  {7'd0, mem_if.mem_addr},    32'd0);
    check("rst_stop",  {31'd0, mem_if.mem_stop},   32'd0);
    check("rst_avail", {31'd0, sd_data_available}, 32'd0);
    check("rst_out",   {16'd0, sd_out},            32'd0);
    check("rst_drop",  {31'd0, req_dropped},       32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare();
    reset_n = 1;
    tick();
    tick();
    check("t5_nstop", n_stop, 32'd0);
    start_log();
    sd_rd = 1; sd_rd_addr = 25'h400; tick();
    check("t5_addr", {7'd0, mem_if.mem_addr}, 32'h400);
    mem_if.mem_ack = 1; tick();
    for (int i = 0; i < BL; i++) begin word(16'(32'hF000 + i)); tick(); end
    mem_if.mem_done = 1; tick();
    check("t5_count", got_words.size(), 32'd8);
    check("t5_first", {16'd0, got_words[0]}, 32'hF000);

    // Randomized traffic
    ctl = 0;
    for (int c = 0; c < 4000; c++) begin
      emu_drive();
      sd_rd        = ($urandom % 12 == 0);
      sd_rd_addr   = AW'($urandom);
      sd_end_burst = ($urandom % 15 == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_burst_reader.md
VIDEO_BURST_READER -- requirements
Module: video_burst_reader

Interface
REQ-001 Parameter BURST_LEN, default 8: words per SDRAM burst, legal range 2..64.
REQ-002 Parameter ADDR_W, default 25: SDRAM word address width.
REQ-003 clk_sys_131_072  in  1  system clock; the block has one clock and uses only this one.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sd_rd  in  1  one-cycle burst request from the video RGB stage.
REQ-006 sd_rd_addr  in  ADDR_W  start address, sampled when sd_rd=1.
REQ-007 sd_end_burst  in  1  consumer request to end the current burst early.
REQ-008 sd_data_available  out  1  sd_out holds a valid word this cycle.
REQ-009 sd_out  out  16  burst data word to the video stage.
REQ-010 mem_req  out  1  burst request to the SDRAM controller, held until acked.
REQ-011 mem_addr  out  ADDR_W  burst start address, stable while mem_req=1.
REQ-012 mem_ack  in  1  controller accepted mem_req.
REQ-013 mem_valid  in  1  mem_data carries a burst word.
REQ-014 mem_data  in  16  controller read data.
REQ-015 mem_stop  out  1  one-cycle pulse to abort the controller's current burst.
REQ-016 mem_done  in  1  controller burst finished (natural end or after mem_stop).
REQ-017 req_dropped  out  1  one-cycle pulse when a pending request is overwritten.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, STREAM and DRAIN.
REQ-019 IDLE: on sd_rd, or when a pending request exists, SHALL load mem_addr and go to REQ on the next cycle.
REQ-020 REQ: mem_req=1; on mem_ack, SHALL deassert mem_req in the same cycle it is sampled, clear the word counter and go to STREAM.
REQ-021 STREAM: each mem_valid SHALL register mem_data into sd_out and assert sd_data_available exactly one cycle later (latency 1), then increment the word counter.
REQ-022 STREAM: the word counter SHALL be clog2(BURST_LEN)+1 bits wide; when the BURST_LEN-th word is accepted, the FSM SHALL go to DRAIN to await mem_done.
REQ-023 STREAM: sd_end_burst with words remaining SHALL pulse mem_stop for 1 cycle, block forwarding of any further mem_valid words, and go to DRAIN.
REQ-024 If sd_end_burst coincides with the last word, that word SHALL be delivered and mem_stop SHALL NOT pulse.
REQ-025 DRAIN: sd_data_available=0, mem_valid words discarded; on mem_done, go to IDLE, or to REQ if a pending request exists.
REQ-026 mem_done arriving in STREAM SHALL end the burst immediately (short burst) with the same transitions as in DRAIN.
REQ-027 A sd_rd in any state other than IDLE SHALL be latched in a one-deep pending slot (valid bit + address).
REQ-028 A sd_rd while the slot is already full SHALL overwrite the address (latest wins) and pulse req_dropped for 1 cycle.
REQ-029 A sd_rd in the same cycle as mem_done SHALL be taken as pending and served next, with no idle cycle.
REQ-030 The pending slot SHALL be cleared on the cycle its request enters REQ.
REQ-031 sd_end_burst outside STREAM SHALL be ignored.

Reset
REQ-032 reset_n=0 SHALL immediately force the state to IDLE and the following to 0: mem_req, mem_addr, mem_stop, sd_data_available, sd_out, req_dropped, word counter, pending slot.
REQ-033 Reset mid-burst SHALL NOT pulse mem_stop; after reset the controller is assumed re-reset with the system.

Structure
REQ-034 The FSM state enum, ADDR_W default and BURST_LEN default SHALL live in shared package video_pkg.
REQ-035 The pending slot SHALL be a sub-module, burst_req_slot (load/overwrite/clear, dropped pulse).

Verification
REQ-036 sd_rd addr=0x000100, ack after 3 cycles, 8 mem_valid words 0xA000..0xA007 -> 8 sd_data_available pulses, each 1 cycle after its word, in order.
REQ-037 sd_end_burst after word 3 -> exactly 4 words out, one mem_stop pulse, words 4..7 suppressed, IDLE after mem_done.
REQ-038 Two sd_rd (0x200, then 0x300) during STREAM -> one req_dropped pulse; the next mem_addr is 0x300.
REQ-039 sd_rd in the same cycle as mem_done -> mem_req=1 on the following cycle with the new address.
REQ-040 reset_n low for 1 cycle mid-STREAM -> all outputs 0 at once, no mem_stop; a new sd_rd then works normally.
REQ-041 sd_end_burst coincident with word 7 -> 8 words delivered, no mem_stop.
